cwe1234_lockable_regbank: RTL and testbench

- Parametrised successor to the single lockable data register: a bank of NREGS registers, each WIDTH bits wide, with a per-register sticky lock.
- Each lock-bypass path (scan, debug) can be enabled independently at elaboration, so both the vulnerable and the mitigated variants of the CWE-1234 pattern come from one block.
- Adds registered readback, rejected-write reporting, a saturating violation counter and an optional clear-on-scan-entry mitigation.
- Used as a fixture for lock-bypass pattern detection across multi-register, multi-bit structures.

---
 rtl/cwe1234_lockable_regbank.sv | 120 ++++++++++++
 tb/tb_cwe1234_lockable_regbank.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cwe1234_lockable_regbank.sv
// Bank of NREGS lockable data registers with sticky per-register locks.
// Scan and debug lock-bypass paths are elaboration options, so the block can be
// built as either the vulnerable or the mitigated form of the lock-bypass
// pattern. Also provides registered readback, rejected-write reporting, a
// saturating violation counter and an optional clear on scan entry.
module cwe1234_lockable_regbank #(
    parameter int WIDTH        = 32,
    parameter int NREGS        = 8,
    parameter int ADDR_W       = 3,
    parameter int CNT_W        = 8,
    parameter bit BYPASS_SCAN  = 1'b1,
    parameter bit BYPASS_DEBUG = 1'b1,
    parameter bit SCAN_CLEAR   = 1'b0
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr,
    input  logic              lock_all,
    input  logic              scan_mode,
    input  logic              debug_unlocked,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic [NREGS-1:0]  lock_status,
    output logic              wr_err,
    output logic [CNT_W-1:0]  viol_count
);

    // Storage spans the whole address space so any address indexes safely;
    // entries at or above NREGS are held at zero and never written, which
    // also makes out-of-range reads return zero.
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] NREGS_C = (ADDR_W + 1)'(NREGS);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] lock_q, lock_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             wr_err_q, wr_err_d;
    logic [CNT_W-1:0] viol_q, viol_d;
    logic             scan_q, scan_d;

    logic wr_in_range, lock_in_range, bypass, scan_rise, permit;
    logic do_write, reject;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Write permission uses the lock bits as they stood before this edge.
    always_comb begin
        wr_in_range   = ({1'b0, wr_addr} < NREGS_C);
        lock_in_range = ({1'b0, lock_addr} < NREGS_C);
        bypass        = (BYPASS_SCAN && scan_mode) || (BYPASS_DEBUG && debug_unlocked);
        scan_rise     = SCAN_CLEAR && scan_mode && !scan_q;
        permit        = wr_in_range && (!lock_q[wr_addr] || bypass);
        // A write colliding with the scan-entry clear is discarded silently.
        do_write      = wr_en && permit && !scan_rise;
        reject        = wr_en && !permit && !scan_rise;
    end

    // Next-state for data, locks, readback and violation reporting.
    always_comb begin
        regs_d = regs_q;
        if (scan_rise) begin
            for (int i = 0; i < DEPTH; i++) regs_d[i] = '0;
        end else if (do_write) begin
            regs_d[wr_addr] = wr_data;
        end
        for (int i = NREGS; i < DEPTH; i++) regs_d[i] = '0;

        lock_d = lock_q;
        if (lock_all) lock_d = '1;
        if (lock_en && lock_in_range) lock_d[lock_addr] = 1'b1;
        for (int i = NREGS; i < DEPTH; i++) lock_d[i] = 1'b0;

        // Read samples the pre-write contents, so read-during-write is old data.
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? regs_q[rd_addr] : rd_data_q;

        wr_err_d = reject;
        viol_d   = reject ? sat_inc(viol_q) : viol_q;
        scan_d   = scan_mode;
    end

    // State registers; reset dominates every other input.
    always_ff @(posedge Clk) begin
        if (reset) begin
            regs_q     <= '{default: '0};
            lock_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
            viol_q     <= '0;
            scan_q     <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            lock_q     <= lock_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_err_q   <= wr_err_d;
            viol_q     <= viol_d;
            scan_q     <= scan_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign lock_status = lock_q[NREGS-1:0];
    assign wr_err      = wr_err_q;
    assign viol_count  = viol_q;

endmodule

// File: tb/tb_cwe1234_lockable_regbank.sv
// Directed bench for two builds of the register bank:
//   instance 0 - defaults (scan and debug bypass enabled, no scan clear)
//   instance 1 - no bypass, scan-entry clear, 2-bit violation counter
module tb_cwe1234_lockable_regbank;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [1:0] reset, wr_en, lock_en, lock_all, scan_mode, debug_unlocked, rd_en;
    logic [2:0]  wr_addr   [2];
    logic [31:0] wr_data   [2];
    logic [2:0]  lock_addr [2];
    logic [2:0]  rd_addr   [2];

    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1, wr_err0, wr_err1;
    logic [7:0]  lock0, lock1;
    logic [7:0]  viol0;
    logic [1:0]  viol1;

    cwe1234_lockable_regbank dut0 (
        .Clk(Clk), .reset(reset[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
        .wr_data(wr_data[0]), .lock_en(lock_en[0]), .lock_addr(lock_addr[0]),
        .lock_all(lock_all[0]), .scan_mode(scan_mode[0]),
        .debug_unlocked(debug_unlocked[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .lock_status(lock0),
        .wr_err(wr_err0), .viol_count(viol0)
    );

    cwe1234_lockable_regbank #(
        .CNT_W(2), .BYPASS_SCAN(1'b0), .BYPASS_DEBUG(1'b0), .SCAN_CLEAR(1'b1)
    ) dut1 (
        .Clk(Clk), .reset(reset[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
        .wr_data(wr_data[1]), .lock_en(lock_en[1]), .lock_addr(lock_addr[1]),
        .lock_all(lock_all[1]), .scan_mode(scan_mode[1]),
        .debug_unlocked(debug_unlocked[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .lock_status(lock1),
        .wr_err(wr_err1), .viol_count(viol1)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] sb0 [$];
    logic [31:0] sb1 [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one edge, then retire any read result against the scoreboard.
    task automatic tick();
        @(posedge Clk);
        #1;
        if (rd_valid0) begin
            if (sb0.size() == 0) chk("rd0_unexpected_valid", 32'(rd_valid0), 32'd0);
            else chk("rd0_data", rd_data0, sb0.pop_front());
        end
        if (rd_valid1) begin
            if (sb1.size() == 0) chk("rd1_unexpected_valid", 32'(rd_valid1), 32'd0);
            else chk("rd1_data", rd_data1, sb1.pop_front());
        end
    endtask

    task automatic wr(input int d, input logic [2:0] a, input logic [31:0] v);
        wr_en[d] = 1'b1; wr_addr[d] = a; wr_data[d] = v;
        tick();
        wr_en[d] = 1'b0;
    endtask

    task automatic rd(input int d, input logic [2:0] a, input logic [31:0] exp);
        rd_en[d] = 1'b1; rd_addr[d] = a;
        if (d == 0) sb0.push_back(exp); else sb1.push_back(exp);
        tick();
        rd_en[d] = 1'b0;
        chk($sformatf("rd%0d_latency_a%0d", d, a), (d == 0) ? sb0.size() : sb1.size(), 32'd0);
    endtask

    task automatic lock_one(input int d, input logic [2:0] a);
        lock_en[d] = 1'b1; lock_addr[d] = a;
        tick();
        lock_en[d] = 1'b0;
    endtask

    initial begin
        reset = '0; wr_en = '0; lock_en = '0; lock_all = '0;
        scan_mode = '0; debug_unlocked = '0; rd_en = '0;
        for (int d = 0; d < 2; d++) begin
            wr_addr[d] = '0; wr_data[d] = '0; lock_addr[d] = '0; rd_addr[d] = '0;
        end

        reset = 2'b11;
        tick(); tick();
        reset = 2'b00;
        chk("rst_rd_data0", rd_data0, 0);
        chk("rst_rd_valid0", 32'(rd_valid0), 0);
        chk("rst_lock0", 32'(lock0), 0);
        chk("rst_wr_err0", 32'(wr_err0), 0);
        chk("rst_viol0", 32'(viol0), 0);
        chk("rst_lock1", 32'(lock1), 0);
        chk("rst_viol1", 32'(viol1), 0);

        // ---- instance 0: vulnerable build ----
        wr(0, 3'd2, 32'hDEADBEEF);
        chk("a_wr_ok_err", 32'(wr_err0), 0);
        rd(0, 3'd2, 32'hDEADBEEF);
        chk("a_lock_init", 32'(lock0), 0);
        chk("a_viol_init", 32'(viol0), 0);

        lock_one(0, 3'd2);
        chk("a_lock2", 32'(lock0), 32'h04);
        wr(0, 3'd2, 32'h12345678);
        chk("a_rej_err", 32'(wr_err0), 1);
        chk("a_rej_viol", 32'(viol0), 1);
        tick();
        chk("a_err_pulse_end", 32'(wr_err0), 0);
        rd(0, 3'd2, 32'hDEADBEEF);

        scan_mode[0] = 1'b1;
        wr(0, 3'd2, 32'hCAFEF00D);
        chk("a_scan_bypass_err", 32'(wr_err0), 0);
        scan_mode[0] = 1'b0;
        rd(0, 3'd2, 32'hCAFEF00D);
        chk("a_scan_bypass_viol", 32'(viol0), 1);

        debug_unlocked[0] = 1'b1;
        wr(0, 3'd2, 32'h11112222);
        chk("a_dbg_bypass_err", 32'(wr_err0), 0);
        debug_unlocked[0] = 1'b0;
        rd(0, 3'd2, 32'h11112222);
        chk("a_lock_sticky", 32'(lock0), 32'h04);

        lock_en[0] = 1'b1; lock_addr[0] = 3'd5;
        wr(0, 3'd5, 32'hA5A5A5A5);
        lock_en[0] = 1'b0;
        chk("a_same_cycle_err", 32'(wr_err0), 0);
        chk("a_lock25", 32'(lock0), 32'h24);
        rd(0, 3'd5, 32'hA5A5A5A5);
        wr(0, 3'd5, 32'h0);
        chk("a_after_lock_err", 32'(wr_err0), 1);
        chk("a_after_lock_viol", 32'(viol0), 2);
        rd(0, 3'd5, 32'hA5A5A5A5);

        wr(0, 3'd3, 32'h00000001);
        wr_en[0] = 1'b1; wr_addr[0] = 3'd3; wr_data[0] = 32'h00000002;
        rd_en[0] = 1'b1; rd_addr[0] = 3'd3; sb0.push_back(32'h00000001);
        tick();
        wr_en[0] = 1'b0; rd_en[0] = 1'b0;
        chk("a_rdw_latency", sb0.size(), 0);
        rd(0, 3'd3, 32'h00000002);
        tick();
        chk("a_idle_valid", 32'(rd_valid0), 0);
        chk("a_idle_hold", rd_data0, 32'h00000002);

        // ---- instance 1: mitigated build with scan clear ----
        for (int i = 0; i < 8; i++) wr(1, 3'(i), 32'h1000 + 32'(i));
        rd(1, 3'd6, 32'h1006);
        lock_one(1, 3'd2);
        wr(1, 3'd2, 32'hBAD0BAD0);
        chk("b_rej_err", 32'(wr_err1), 1);
        chk("b_rej_viol", 32'(viol1), 1);

        lock_all[1] = 1'b1;
        tick();
        lock_all[1] = 1'b0;
        chk("b_lock_all", 32'(lock1), 32'hFF);

        scan_mode[1] = 1'b1;
        wr(1, 3'd0, 32'hFFFFFFFF);
        chk("b_clear_no_err", 32'(wr_err1), 0);
        chk("b_clear_no_viol", 32'(viol1), 1);
        for (int i = 0; i < 8; i++) rd(1, 3'(i), 32'h0);
        chk("b_clear_keeps_lock", 32'(lock1), 32'hFF);

        wr(1, 3'd2, 32'hCAFEF00D);
        chk("b_no_scan_bypass_err", 32'(wr_err1), 1);
        chk("b_no_scan_bypass_viol", 32'(viol1), 2);
        rd(1, 3'd2, 32'h0);

        debug_unlocked[1] = 1'b1;
        wr(1, 3'd3, 32'h33333333);
        chk("b_no_dbg_bypass_viol", 32'(viol1), 3);
        wr(1, 3'd3, 32'h44444444);
        chk("b_sat_viol_4", 32'(viol1), 3);
        wr(1, 3'd4, 32'h55555555);
        chk("b_sat_viol_5", 32'(viol1), 3);
        chk("b_sat_err", 32'(wr_err1), 1);
        debug_unlocked[1] = 1'b0;
        scan_mode[1] = 1'b0;

        reset[1] = 1'b1;
        wr(1, 3'd1, 32'h66666666);
        reset[1] = 1'b0;
        chk("b_rst_viol", 32'(viol1), 0);
        chk("b_rst_lock", 32'(lock1), 0);
        chk("b_rst_err", 32'(wr_err1), 0);
        wr(1, 3'd2, 32'h00000077);
        chk("b_post_rst_err", 32'(wr_err1), 0);
        rd(1, 3'd2, 32'h00000077);
        rd(1, 3'd1, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
